if_id_buffer: RTL and testbench

IF_ID_BUFFER -- requirements
Module: if_id_buffer

---
 rtl/if_id_buffer.sv | 76 +++++++
 tb/tb_if_id_buffer.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/if_id_buffer.sv
// IF/ID pipeline buffer: a DEPTH-entry circular FIFO between fetch and decode with freeze and flush.
// Define IF_ID_BUF_STATS_EN to add the stallCount/flushCount statistics outputs. DEPTH must be a power of two (2..8).
module if_id_buffer #(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic [31:0] inPC,
  input  logic [31:0] inInstruction,
  output logic        fetchFreeze,
  input  logic        idStall,
  output logic        outValid,
  output logic [31:0] outPC,
  output logic [31:0] outInstruction
`ifdef IF_ID_BUF_STATS_EN
  ,
  output logic [31:0] stallCount,
  output logic [31:0] flushCount
`endif
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } entry_t;

  entry_t        mem [DEPTH];
  entry_t        head;
  logic [PW-1:0] wptr, rptr;
  logic [CW-1:0] count;
  logic          push, pop;

  // Freeze and valid come straight from the count register, so fetch sees no input-to-output path.
  assign fetchFreeze    = (count == CW'(DEPTH));
  assign outValid       = (count != '0);
  assign push           = ~fetchFreeze & ~flush;
  assign pop            = outValid & ~idStall & ~flush;
  assign head           = mem[rptr];
  assign outPC          = outValid ? head.pc    : 32'h0;
  assign outInstruction = outValid ? head.instr : 32'h0;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      // DEPTH is a power of two, so the natural pointer overflow is the DEPTH-1 -> 0 wrap.
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end

  // Storage is never cleared; stale contents are masked by outValid.
  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= {inPC, inInstruction};
  end

`ifdef IF_ID_BUF_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stallCount <= '0;
      flushCount <= '0;
    end else begin
      if (fetchFreeze && !flush) stallCount <= stallCount + 32'd1;
      if (flush)                 flushCount <= flushCount + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_if_id_buffer.sv
// Bench for if_id_buffer: DEPTH=2 vector table with hand-derived results, DEPTH=4 queue-model scoreboard.
// Statistics outputs are checked when IF_ID_BUF_STATS_EN is defined.
module tb_if_id_buffer;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // DEPTH=2 instance
  logic        rst2 = 1'b1, flush2 = 1'b0, stall2 = 1'b0;
  logic [31:0] pc2 = '0, ins2 = '0;
  logic        fz2, v2;
  logic [31:0] opc2, oins2;
  // DEPTH=4 instance
  logic        rst4 = 1'b1, flush4 = 1'b0, stall4 = 1'b0;
  logic [31:0] pc4 = '0, ins4 = '0;
  logic        fz4, v4;
  logic [31:0] opc4, oins4;
`ifdef IF_ID_BUF_STATS_EN
  logic [31:0] sc2, fc2, sc4, fc4;
`endif

  if_id_buffer #(.DEPTH(2)) u_dut2 (
    .clk(clk), .rst(rst2), .flush(flush2), .inPC(pc2), .inInstruction(ins2),
    .fetchFreeze(fz2), .idStall(stall2), .outValid(v2), .outPC(opc2), .outInstruction(oins2)
`ifdef IF_ID_BUF_STATS_EN
    , .stallCount(sc2), .flushCount(fc2)
`endif
  );

  if_id_buffer #(.DEPTH(4)) u_dut4 (
    .clk(clk), .rst(rst4), .flush(flush4), .inPC(pc4), .inInstruction(ins4),
    .fetchFreeze(fz4), .idStall(stall4), .outValid(v4), .outPC(opc4), .outInstruction(oins4)
`ifdef IF_ID_BUF_STATS_EN
    , .stallCount(sc4), .flushCount(fc4)
`endif
  );

  function automatic logic [31:0] ins_of(input logic [31:0] pc);
    return 32'hE3A0_0000 + (pc >> 2);
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got %h expected %h", name, got, exp);
    end
  endtask

  typedef struct {
    logic        r, f, s;
    logic [31:0] pc;
    logic        v;
    logic [31:0] epc;
    logic        fz;
  } vec_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] ins;
  } ent_t;

  ent_t q[$];
  int   stm = 0, flm = 0;

  // One DEPTH=4 cycle: model push/pop from pre-edge state, then compare after the edge.
  task automatic step4(input logic r, input logic f, input logic s, input logic [31:0] pc);
    bit full, pu, po;
    @(negedge clk);
    rst4 = r; flush4 = f; stall4 = s; pc4 = pc; ins4 = ins_of(pc);
    full = (q.size() == 4);
    pu   = !full && !f;
    po   = (q.size() != 0) && !s && !f;
    @(posedge clk);
    if (r) begin
      q.delete(); stm = 0; flm = 0;
    end else if (f) begin
      q.delete(); flm++;
    end else begin
      if (full) stm++;
      if (po) void'(q.pop_front());
      if (pu) q.push_back({pc, ins_of(pc)});
    end
    #1;
    chk("d4_valid",  {31'b0, v4},  {31'b0, q.size() != 0});
    chk("d4_pc",     opc4,  q.size() != 0 ? q[0].pc  : 32'h0);
    chk("d4_instr",  oins4, q.size() != 0 ? q[0].ins : 32'h0);
    chk("d4_freeze", {31'b0, fz4}, {31'b0, q.size() == 4});
`ifdef IF_ID_BUF_STATS_EN
    chk("d4_stallcnt", sc4, stm);
    chk("d4_flushcnt", fc4, flm);
`endif
  endtask

  vec_t tbl[18];

  initial begin
    //          r  f  s  pc      v  epc  fz
    tbl[0]  = '{1, 0, 0, 0,      0, 0,   0};  // reset state
    tbl[1]  = '{0, 0, 0, 4,      1, 4,   0};  // latency-1 push
    tbl[2]  = '{0, 1, 0, 8,      0, 0,   0};  // no new entry -> bubble
    tbl[3]  = '{0, 0, 1, 4,      1, 4,   0};
    tbl[4]  = '{0, 0, 1, 8,      1, 4,   1};  // full
    tbl[5]  = '{0, 0, 1, 12,     1, 4,   1};  // 12 refused
    tbl[6]  = '{0, 0, 0, 12,     1, 8,   0};  // pop in full cycle frees slot
    tbl[7]  = '{0, 0, 0, 12,     1, 12,  0};
    tbl[8]  = '{0, 0, 1, 16,     1, 12,  1};
    tbl[9]  = '{0, 0, 0, 20,     1, 16,  0};  // full: pop + blocked push, 2->1
    tbl[10] = '{0, 0, 1, 20,     1, 16,  1};
    tbl[11] = '{0, 1, 1, 24,     0, 0,   0};  // flush beats stall and push
    tbl[12] = '{0, 0, 1, 104,    1, 104, 0};
    tbl[13] = '{0, 0, 1, 108,    1, 104, 1};
    tbl[14] = '{1, 1, 0, 112,    0, 0,   0};  // rst + flush with 2 entries
    tbl[15] = '{0, 0, 0, 116,    1, 116, 0};
    tbl[16] = '{0, 0, 0, 120,    1, 120, 0};
    tbl[17] = '{0, 1, 1, 124,    0, 0,   0};

    for (int i = 0; i < 18; i++) begin
      @(negedge clk);
      rst2 = tbl[i].r; flush2 = tbl[i].f; stall2 = tbl[i].s;
      pc2 = tbl[i].pc; ins2 = ins_of(tbl[i].pc);
      @(posedge clk);
      #1;
      chk($sformatf("d2_valid[%0d]", i),  {31'b0, v2}, {31'b0, tbl[i].v});
      chk($sformatf("d2_pc[%0d]", i),     opc2, tbl[i].epc);
      chk($sformatf("d2_instr[%0d]", i),  oins2, tbl[i].v ? ins_of(tbl[i].epc) : 32'h0);
      chk($sformatf("d2_freeze[%0d]", i), {31'b0, fz2}, {31'b0, tbl[i].fz});
`ifdef IF_ID_BUF_STATS_EN
      if (i == 13) begin
        chk("d2_stallcnt_13", sc2, 32'd3);
        chk("d2_flushcnt_13", fc2, 32'd2);
      end
      if (i == 14) begin
        chk("d2_stallcnt_rst", sc2, 32'd0);
        chk("d2_flushcnt_rst", fc2, 32'd0);
      end
      if (i == 17) begin
        chk("d2_stallcnt_end", sc2, 32'd0);
        chk("d2_flushcnt_end", fc2, 32'd1);
      end
`endif
    end
    rst2 = 1'b1;

    // Continuous streaming: one push and one pop per cycle, pointers wrap 5 times.
    step4(1'b1, 1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 21; i++) begin
      step4(1'b0, 1'b0, 1'b0, 32'd200 + 32'(4 * i));
      chk("d4_stream_latency", opc4, 32'd200 + 32'(4 * i));
    end

    // Random stall/flush/reset mix against the queue model.
    for (int i = 0; i < 300; i++) begin
      step4($urandom_range(0, 49) == 0, $urandom_range(0, 11) == 0,
            1'($urandom_range(0, 1)), 32'h1000 + 32'(4 * i));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
